// File: rtl/ir_frame_tx.sv
`timescale 1ns/1ps
// Serial IR frame transmitter: start pulse (low), NBITS data bits MSB first, guard gap (high).
// Latency: line goes low the cycle after send is accepted; frame occupies START+NBITS*BIT+GAP cycles.
// Backpressure: send is only sampled in IDLE; requests while busy are dropped, never queued.
//
// Ports:
//   clk      system clock, posedge
//   rst      asynchronous active-high reset
//   send     frame request, sampled in IDLE only (including the done cycle)
//   code     NBITS payload, captured together with an accepted send
//   irda_tx  registered serial line, idle high, active-low start pulse
//   busy     registered, high from the cycle after acceptance to end of gap
//   done     registered one-cycle pulse on return to IDLE
module ir_frame_tx #(
  parameter int NBITS     = 3,
  parameter int START_CYC = 180,
  parameter int BIT_CYC   = 20,
  parameter int GAP_CYC   = 64,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send,
  input  logic [NBITS-1:0] code,
  output logic             irda_tx,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_MSB    = IDX_W'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   count, count_nx;
  logic [IDX_W-1:0]   idx, idx_nx, idx_dec;
  logic [NBITS-1:0]   shreg, shreg_nx;
  logic               tx_nx, busy_nx, done_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      idx     <= '0;
      shreg   <= '0;
      irda_tx <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      count   <= count_nx;
      idx     <= idx_nx;
      shreg   <= shreg_nx;
      irda_tx <= tx_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

  assign idx_dec = idx - 1'b1;

  // Outputs are computed for the *next* state so they can be registered
  // without adding a cycle of latency relative to the state register.
  always_comb begin
    state_nx = state;
    count_nx = count + 1'b1;
    idx_nx   = idx;
    shreg_nx = shreg;
    tx_nx    = 1'b1;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;

    case (state)
      IDLE: begin
        count_nx = '0;
        if (send) begin
          shreg_nx = code;
          state_nx = START;
          tx_nx    = 1'b0;
          busy_nx  = 1'b1;
        end
      end

      START: begin
        busy_nx = 1'b1;
        tx_nx   = 1'b0;
        if (count == START_LAST) begin
          count_nx = '0;
          idx_nx   = IDX_MSB;
          state_nx = DATA;
          tx_nx    = shreg[NBITS-1];
        end
      end

      DATA: begin
        busy_nx = 1'b1;
        tx_nx   = shreg[idx];
        if (count == BIT_LAST) begin
          count_nx = '0;
          if (idx == '0) begin
            state_nx = GAP;
            tx_nx    = 1'b1;
          end else begin
            idx_nx = idx_dec;
            tx_nx  = shreg[idx_dec];
          end
        end
      end

      GAP: begin
        busy_nx = 1'b1;
        if (count == GAP_LAST) begin
          count_nx = '0;
          state_nx = IDLE;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end
      end

      default: begin
        // Corrupted encoding: park safely with the line idle.
        state_nx = IDLE;
        count_nx = '0;
        idx_nx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ir_frame_tx.sv
`timescale 1ns/1ps
module tb_ir_frame_tx;

  localparam int NBITS     = 3;
  localparam int START_CYC = 4;
  localparam int BIT_CYC   = 2;
  localparam int GAP_CYC   = 3;
  localparam int FRAME     = START_CYC + NBITS * BIT_CYC + GAP_CYC;  // 13 busy cycles
  localparam int PERIOD    = FRAME + 1;                             // plus the done cycle

  logic             clk = 1'b0;
  logic             rst;
  logic             send;
  logic [NBITS-1:0] code;
  logic             irda_tx;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  ir_frame_tx #(
    .NBITS(NBITS), .START_CYC(START_CYC), .BIT_CYC(BIT_CYC),
    .GAP_CYC(GAP_CYC), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .send(send), .code(code),
    .irda_tx(irda_tx), .busy(busy), .done(done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One clock: outputs are sampled 1ns after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected line level at frame cycle p (1-based) for payload c.
  function automatic logic exp_tx(input logic [NBITS-1:0] c, input int p);
    if (p <= START_CYC) return 1'b0;
    else if (p <= START_CYC + NBITS * BIT_CYC) return c[NBITS-1 - (p - START_CYC - 1) / BIT_CYC];
    else return 1'b1;
  endfunction

  typedef struct {
    logic [NBITS-1:0] code;
    logic [FRAME-1:0] pat;   // MSB = first cycle after acceptance
  } vec_t;

  vec_t vecs[5];

  // ---------------- scoreboard receiver ----------------
  logic [NBITS-1:0] sb_q[$];
  bit               rx_en = 1'b0;
  bit               rx_act = 1'b0;
  bit               rx_start_ok;
  int               rx_cnt = 0;
  int               n_decoded = 0;
  logic [NBITS-1:0] rx_bits;

  always @(posedge clk) begin
    #1;
    if (!rx_act) begin
      if (rx_en && irda_tx === 1'b0) begin
        rx_act      = 1'b1;
        rx_cnt      = 1;
        rx_bits     = '0;
        rx_start_ok = 1'b1;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt <= START_CYC && irda_tx !== 1'b0) rx_start_ok = 1'b0;
      for (int i = 0; i < NBITS; i++)
        if (rx_cnt == START_CYC + 1 + i * BIT_CYC + BIT_CYC / 2) rx_bits[NBITS-1-i] = irda_tx;
      if (rx_cnt == START_CYC + NBITS * BIT_CYC) begin
        rx_act = 1'b0;
        n_decoded++;
        check("rx_start_len", {31'd0, rx_start_ok}, 32'd1);
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL rx_unexpected_frame: got code %0h, expected no frame", rx_bits);
        end else begin
          check("rx_code", {29'd0, rx_bits}, {29'd0, sb_q.pop_front()});
        end
      end
    end
  end

  // Single frame with optional stray send/code change at frame cycle inj.
  task automatic run_frame(input logic [NBITS-1:0] c, input logic [FRAME-1:0] pat, input int inj);
    code = c;
    send = 1'b1;
    step();
    send = 1'b0;
    for (int p = 1; p <= FRAME; p++) begin
      check($sformatf("tx c=%0h p=%0d", c, p), {31'd0, irda_tx}, {31'd0, pat[FRAME-p]});
      check($sformatf("busy c=%0h p=%0d", c, p), {31'd0, busy}, 32'd1);
      if (p == 1) check("done_low_in_frame", {31'd0, done}, 32'd0);
      if (p == inj) begin
        send = 1'b1;
        code = 3'b010;
      end else begin
        send = 1'b0;
      end
      step();
    end
    check($sformatf("done c=%0h", c), {31'd0, done}, 32'd1);
    check($sformatf("busy_end c=%0h", c), {31'd0, busy}, 32'd0);
    check($sformatf("tx_end c=%0h", c), {31'd0, irda_tx}, 32'd1);
    step();
    check($sformatf("done_pulse c=%0h", c), {31'd0, done}, 32'd0);
  endtask

  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check({name, "_tx"}, {31'd0, irda_tx}, 32'd1);
      check({name, "_busy"}, {31'd0, busy}, 32'd0);
      check({name, "_done"}, {31'd0, done}, 32'd0);
      step();
    end
  endtask

  initial begin
    int base;
    int n_done;
    int t;
    logic [NBITS-1:0] c;

    vecs[0] = '{3'b101, 13'b0000_11_00_11_111};
    vecs[1] = '{3'b000, 13'b0000_00_00_00_111};
    vecs[2] = '{3'b111, 13'b0000_11_11_11_111};
    vecs[3] = '{3'b010, 13'b0000_00_11_00_111};
    vecs[4] = '{3'b110, 13'b0000_11_11_00_111};

    rst  = 1'b0;
    send = 1'b0;
    code = '0;
    #1 rst = 1'b1;
    #2;
    check("rst_tx", {31'd0, irda_tx}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    repeat (3) step();
    rst = 1'b0;
    idle_check("post_rst", 5);

    // Table-driven frames
    foreach (vecs[i]) begin
      run_frame(vecs[i].code, vecs[i].pat, 0);
      idle_check("gap_idle", 2);
    end

    // Stray send mid-frame is ignored and not queued
    run_frame(3'b101, vecs[0].pat, 5);
    idle_check("no_second_frame", 20);

    // send held high: back-to-back frames, one idle (done) cycle between
    rx_en  = 1'b1;
    base   = n_decoded;
    n_done = 0;
    repeat (4) sb_q.push_back(3'b110);
    code = 3'b110;
    send = 1'b1;
    for (int s = 1; s <= 4 * PERIOD + 4; s++) begin
      step();
      if (s == 3 * PERIOD + 1) send = 1'b0;
      if (done === 1'b1) n_done++;
      if ((s - 1) / PERIOD < 4) begin
        int p;
        p = (s - 1) % PERIOD + 1;
        check($sformatf("held_tx s=%0d", s), {31'd0, irda_tx},
              {31'd0, (p <= FRAME) ? exp_tx(3'b110, p) : 1'b1});
        check($sformatf("held_done s=%0d", s), {31'd0, done}, {31'd0, p == PERIOD});
      end else begin
        check($sformatf("held_after_tx s=%0d", s), {31'd0, irda_tx}, 32'd1);
        check($sformatf("held_after_busy s=%0d", s), {31'd0, busy}, 32'd0);
      end
    end
    check("held_done_count", n_done, 32'd4);
    check("held_decoded", n_decoded - base, 32'd4);
    rx_en = 1'b0;
    idle_check("after_held", 2);

    // Async reset in the middle of data bit 1 (code 101 -> bit 1 is low)
    code = 3'b101;
    send = 1'b1;
    step();
    send = 1'b0;
    repeat (START_CYC + BIT_CYC) step();
    check("pre_rst_bit1_tx", {31'd0, irda_tx}, 32'd0);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_tx", {31'd0, irda_tx}, 32'd1);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    step();
    step();
    rst = 1'b0;
    idle_check("after_rst_idle", 20);
    run_frame(3'b101, vecs[0].pat, 0);

    // Random codes and gaps through the mid-bit receiver
    rx_en = 1'b1;
    base  = n_decoded;
    for (int k = 0; k < 200; k++) begin
      c    = NBITS'($urandom_range(0, (1 << NBITS) - 1));
      code = c;
      send = 1'b1;
      sb_q.push_back(c);
      step();
      send = 1'b0;
      t = 0;
      while (done !== 1'b1 && t < 40) begin
        step();
        t++;
      end
      check($sformatf("rand_done_seen k=%0d", k), {31'd0, done}, 32'd1);
      repeat ($urandom_range(0, 4)) step();
    end
    repeat (3) step();
    check("rand_decoded", n_decoded - base, 32'd200);
    check("sb_empty", sb_q.size(), 32'd0);
    rx_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
